// File: rtl/i2c_bit_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_bit_ctrl
//   Bit-level I2C symbol engine. Executes one bus symbol per accepted command
//   (START, STOP, WRITE-bit, READ-bit). Every symbol is four quarter-phases
//   long, and the prescaler's divided clock supplies the time base. Sits
//   between the clock prescaler and the byte-level I2C master FSM.
//
// Parameters
//   TICKS_PER_QTR  prescaler rising edges per quarter-phase (>= 1)
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   presc_in   divided clock from the prescaler
//   presc_en   prescaler enable, high while a command executes
//   cmd_valid  command request
//   cmd        00=START 01=STOP 10=WRITE 11=READ
//   cmd_din    bit to write (WRITE only)
//   cmd_ready  high when idle and able to accept a command
//   done       one-cycle pulse at command completion
//   dout       sampled SDA from the last READ
//   arb_lost   valid with done: a WRITE of 1 saw SDA low
//   scl        SCL level
//   sda_oe     1 = pull SDA low, 0 = release
//   sda_in     SDA pin level
// -----------------------------------------------------------------------------
module i2c_bit_ctrl #(
   parameter int TICKS_PER_QTR = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       presc_in,
   output logic       presc_en,
   input  logic       cmd_valid,
   input  logic [1:0] cmd,
   input  logic       cmd_din,
   output logic       cmd_ready,
   output logic       done,
   output logic       dout,
   output logic       arb_lost,
   output logic       scl,
   output logic       sda_oe,
   input  logic       sda_in
);

   localparam int QW = (TICKS_PER_QTR > 1) ? $clog2(TICKS_PER_QTR) : 1;
   localparam logic [QW-1:0] QTR_LAST = QW'(TICKS_PER_QTR - 1);

   localparam logic [1:0] CMD_START = 2'b00;
   localparam logic [1:0] CMD_STOP  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_STOP,
      S_WRITE,
      S_READ
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    phase, phase_nxt;
   logic [QW-1:0] qtr_cnt, qtr_nxt;

   logic          presc_q;
   logic [1:0]    cmd_q;
   logic          din_q;
   logic          arb_lost_int;

   logic          tick;
   logic          phase_end;
   logic          accept;
   logic          finish;
   logic          sample;
   logic          drv_scl;
   logic          drv_oe;

   // Next-state, counters and per-phase bus drive
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      qtr_nxt   = qtr_cnt;
      drv_scl   = scl;
      drv_oe    = sda_oe;

      tick      = presc_in & ~presc_q;
      // presc_in is meaningless while idle, so ticks only count in a command.
      phase_end = (state != S_IDLE) && tick && (qtr_cnt == QTR_LAST);
      accept    = cmd_valid && cmd_ready;
      finish    = phase_end && (phase == 2'd3);
      sample    = phase_end && (phase == 2'd2);

      case (state)
         S_IDLE: begin
            if (accept) begin
               phase_nxt = 2'd0;
               qtr_nxt   = '0;
               case (cmd)
                  CMD_START: state_nxt = S_START;
                  CMD_STOP:  state_nxt = S_STOP;
                  CMD_WRITE: state_nxt = S_WRITE;
                  default:   state_nxt = S_READ;
               endcase
            end
         end
         default: begin
            if (tick) begin
               if (phase_end) begin
                  qtr_nxt = '0;
                  if (phase == 2'd3) begin
                     state_nxt = S_IDLE;
                     phase_nxt = 2'd0;
                  end else begin
                     phase_nxt = phase + 2'd1;
                  end
               end else begin
                  qtr_nxt = qtr_cnt + QW'(1);
               end
            end
         end
      endcase

      case (state)
         S_START: begin
            drv_scl = (phase != 2'd3);
            drv_oe  = (phase != 2'd0);
         end
         S_STOP: begin
            drv_scl = (phase != 2'd0);
            drv_oe  = (phase != 2'd3);
         end
         S_WRITE: begin
            drv_scl = (phase == 2'd1) || (phase == 2'd2);
            drv_oe  = ~din_q;
         end
         S_READ: begin
            drv_scl = (phase == 2'd1) || (phase == 2'd2);
            drv_oe  = 1'b0;
         end
         default: begin
            // Idle: SCL keeps its level; SDA stays pulled low only after a
            // START so the bus remains in the started condition.
            drv_scl = scl;
            drv_oe  = sda_oe & (cmd_q == CMD_START);
         end
      endcase
   end

   // Registered state and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         phase        <= 2'd0;
         qtr_cnt      <= '0;
         presc_q      <= 1'b0;
         cmd_q        <= CMD_STOP;
         arb_lost_int <= 1'b0;
         scl          <= 1'b1;
         sda_oe       <= 1'b0;
         presc_en     <= 1'b0;
         cmd_ready    <= 1'b1;
         done         <= 1'b0;
         dout         <= 1'b0;
         arb_lost     <= 1'b0;
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         qtr_cnt  <= qtr_nxt;
         // Cleared on accept so a prescaler edge left over from idle time
         // cannot be mistaken for the first tick.
         presc_q  <= accept ? 1'b0 : presc_in;
         scl      <= drv_scl;
         sda_oe   <= drv_oe;
         done     <= finish;
         arb_lost <= finish & arb_lost_int;

         if (accept) begin
            cmd_q        <= cmd;
            din_q        <= cmd_din;
            arb_lost_int <= 1'b0;
            cmd_ready    <= 1'b0;
            presc_en     <= 1'b1;
         end else if (finish) begin
            cmd_ready    <= 1'b1;
            presc_en     <= 1'b0;
         end

         // SDA is sampled at the end of the SCL-high window (phase 2).
         if (sample && (state == S_READ)) begin
            dout <= sda_in;
         end
         if (sample && (state == S_WRITE) && din_q) begin
            arb_lost_int <= ~sda_in;
         end
      end
   end

endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_bit_ctrl
//   Self-checking bench for i2c_bit_ctrl (TICKS_PER_QTR = 1). A prescaler
//   model produces a period-4 square wave while presc_en is high. Commands
//   are checked against a table-driven model of the bus symbols.
// -----------------------------------------------------------------------------
module tb_i2c_bit_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       presc_in = 1'b0;
   logic       presc_en;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic       cmd_din = 1'b0;
   logic       cmd_ready;
   logic       done;
   logic       dout;
   logic       arb_lost;
   logic       scl;
   logic       sda_oe;
   logic       sda_in = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [1:0] C_START = 2'b00;
   localparam logic [1:0] C_STOP  = 2'b01;
   localparam logic [1:0] C_WRITE = 2'b10;
   localparam logic [1:0] C_READ  = 2'b11;

   // Expected bus levels per command, bit p = quarter-phase p.
   logic [3:0] scl_tab [4];
   logic [3:0] oe_tab  [4];

   // Reference state carried between commands
   logic model_scl  = 1'b1;
   logic model_oe   = 1'b0;
   logic model_dout = 1'b0;

   logic [2:0] pc = 3'd0;

   i2c_bit_ctrl #(.TICKS_PER_QTR(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .presc_in  (presc_in),
      .presc_en  (presc_en),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .cmd_din   (cmd_din),
      .cmd_ready (cmd_ready),
      .done      (done),
      .dout      (dout),
      .arb_lost  (arb_lost),
      .scl       (scl),
      .sda_oe    (sda_oe),
      .sda_in    (sda_in)
   );

   always #5 clk = ~clk;

   // Prescaler model: square wave of period 4 clocks, restarts low when disabled.
   always @(negedge clk) begin
      if (!presc_en) pc = 3'd0;
      else           pc = pc + 3'd1;
      presc_in = pc[1];
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("idle_scl", 8'(scl), 8'(model_scl));
         chk("idle_oe", 8'(sda_oe), 8'(model_oe));
         chk("idle_ready", 8'(cmd_ready), 8'd1);
         chk("idle_presc_en", 8'(presc_en), 8'd0);
         chk("idle_done", 8'(done), 8'd0);
         chk("idle_arb", 8'(arb_lost), 8'd0);
      end
   endtask

   // Issue one command at a falling edge and follow it to its done pulse.
   // s2 is the SDA level presented during quarter-phase 2; poke raises a
   // READ request while busy, which must be ignored.
   task automatic do_cmd(input logic [1:0] c, input logic d, input logic s2, input logic poke);
      logic exp_oe;
      logic exp_arb;
      logic exp_dout;
      int   p;
      chk("ready_pre", 8'(cmd_ready), 8'd1);
      cmd_valid = 1'b1;
      cmd       = c;
      cmd_din   = d;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = 2'($urandom);
      cmd_din   = 1'($urandom);
      exp_arb   = (c == C_WRITE) && d && !s2;
      exp_dout  = (c == C_READ) ? s2 : model_dout;
      for (int t = 0; t <= 14; t++) begin
         if (t == 1) begin
            chk("presc_en_busy", 8'(presc_en), 8'd1);
            chk("ready_busy", 8'(cmd_ready), 8'd0);
            chk("dout_hold", 8'(dout), 8'(model_dout));
         end
         if ((t % 4) == 2) begin
            p      = t / 4;
            exp_oe = (c == C_WRITE) ? ~d : oe_tab[c][p];
            chk("scl_phase", 8'(scl), 8'(scl_tab[c][p]));
            chk("oe_phase", 8'(sda_oe), 8'(exp_oe));
         end
         if (t < 14) begin
            chk("done_early", 8'(done), 8'd0);
            chk("arb_early", 8'(arb_lost), 8'd0);
         end else begin
            chk("done_pulse", 8'(done), 8'd1);
            chk("arb_at_done", 8'(arb_lost), 8'(exp_arb));
            chk("dout_at_done", 8'(dout), 8'(exp_dout));
            chk("presc_en_done", 8'(presc_en), 8'd0);
            chk("ready_done", 8'(cmd_ready), 8'd1);
         end
         if (t == 5 && poke) begin
            cmd_valid = 1'b1;
            cmd       = C_READ;
         end
         if (t == 6) begin
            cmd_valid = 1'b0;
            sda_in    = s2;
         end
         if (t == 10) sda_in = 1'($urandom);
         if (t < 14) @(negedge clk);
      end
      model_dout = exp_dout;
      model_scl  = scl_tab[c][3];
      model_oe   = (c == C_START);
   endtask

   initial begin
      scl_tab[C_START] = 4'b0111;  oe_tab[C_START] = 4'b1110;
      scl_tab[C_STOP]  = 4'b1110;  oe_tab[C_STOP]  = 4'b0111;
      scl_tab[C_WRITE] = 4'b0110;  oe_tab[C_WRITE] = 4'b0000;
      scl_tab[C_READ]  = 4'b0110;  oe_tab[C_READ]  = 4'b0000;

      // Reset values
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_scl", 8'(scl), 8'd1);
      chk("rst_oe", 8'(sda_oe), 8'd0);
      chk("rst_ready", 8'(cmd_ready), 8'd1);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_presc_en", 8'(presc_en), 8'd0);
      chk("rst_dout", 8'(dout), 8'd0);
      chk("rst_arb", 8'(arb_lost), 8'd0);
      rst = 1'b0;
      idle_gap(2);

      // START then WRITE 0, back to back
      do_cmd(C_START, 1'b0, 1'b1, 1'b0);
      do_cmd(C_WRITE, 1'b0, 1'b1, 1'b0);
      idle_gap(1);

      // READ 1 then READ 0
      do_cmd(C_READ, 1'b0, 1'b1, 1'b0);
      do_cmd(C_READ, 1'b1, 1'b0, 1'b0);
      idle_gap(1);

      // Arbitration: WRITE 1 with SDA low, then with SDA high
      do_cmd(C_WRITE, 1'b1, 1'b0, 1'b0);
      do_cmd(C_WRITE, 1'b1, 1'b1, 1'b0);
      idle_gap(1);

      // Reset in the middle of a WRITE
      chk("ready_pre_rst", 8'(cmd_ready), 8'd1);
      cmd_valid = 1'b1;
      cmd       = C_WRITE;
      cmd_din   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_scl", 8'(scl), 8'd1);
      chk("abort_oe", 8'(sda_oe), 8'd0);
      chk("abort_ready", 8'(cmd_ready), 8'd1);
      chk("abort_presc_en", 8'(presc_en), 8'd0);
      chk("abort_done", 8'(done), 8'd0);
      rst        = 1'b0;
      model_scl  = 1'b1;
      model_oe   = 1'b0;
      model_dout = 1'b0;
      idle_gap(16);

      // Busy request ignored during START, then STOP
      do_cmd(C_START, 1'b0, 1'b1, 1'b1);
      do_cmd(C_STOP, 1'b0, 1'b1, 1'b0);
      idle_gap(2);

      // Randomized command stream
      for (int i = 0; i < 40; i++) begin
         do_cmd(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         idle_gap($urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
